// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer for the MIPS datapath.
// Issues req/ack fetches at the current PC and hands each word to decode over valid/ready.
module pc_fetch_unit #(
  parameter int PC_W     = 6,
  parameter int INSTR_W  = 32,
  parameter int RESET_PC = 0,
  parameter int INC      = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    inc_o,
  input  logic [PC_W-1:0]    pc_plus_i,
  input  logic               pc_cout_i,
  input  logic               branch_taken_i,
  input  logic [PC_W-1:0]    branch_target_i,
  input  logic               jump_i,
  input  logic [PC_W-1:0]    jump_target_i,
  input  logic               stall_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic               pc_wrapped_o
);

  localparam logic [PC_W-1:0] ResetPcVal = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] IncVal     = PC_W'(INC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W-1:0]      pend_tgt_q, pend_tgt_d;
  logic                 pend_v_q, pend_v_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 pc_wrapped_q, pc_wrapped_d;
  logic                 redirect;
  logic [PC_W-1:0]      redir_tgt;

  // Jump outranks branch when both arrive in the same cycle.
  assign redirect  = jump_i | branch_taken_i;
  assign redir_tgt = jump_i ? jump_target_i : branch_target_i;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_tgt_d    = pend_tgt_q;
    pend_v_d      = pend_v_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_wrapped_d  = pc_wrapped_q;

    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = redir_tgt;
        end
        if (!stall_i) begin
          state_d = REQ;
        end
      end

      // The address must not move while a request is outstanding, so redirects are parked.
      REQ: begin
        if (imem_ack_i) begin
          if (redirect) begin
            pc_d     = redir_tgt;
            pend_v_d = 1'b0;
            state_d  = IDLE;
          end else if (pend_v_q) begin
            pc_d     = pend_tgt_q;
            pend_v_d = 1'b0;
            state_d  = IDLE;
          end else begin
            instr_d       = imem_data_i;
            instr_valid_d = 1'b1;
            pc_d          = pc_plus_i;
            if (pc_cout_i) begin
              pc_wrapped_d = 1'b1;
            end
            state_d = HOLD;
          end
        end else if (redirect) begin
          pend_tgt_d = redir_tgt;
          pend_v_d   = 1'b1;
        end
      end

      HOLD: begin
        if (redirect) begin
          instr_valid_d = 1'b0;
          pc_d          = redir_tgt;
          state_d       = IDLE;
        end else if (instr_ready_i && !stall_i) begin
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      pc_q          <= ResetPcVal;
      pend_tgt_q    <= '0;
      pend_v_q      <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pc_wrapped_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_tgt_q    <= pend_tgt_d;
      pend_v_q      <= pend_v_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_wrapped_q  <= pc_wrapped_d;
    end
  end

  assign pc_o          = pc_q;
  assign inc_o         = IncVal;
  assign imem_addr_o   = pc_q;
  assign imem_req_o    = (state_q == REQ);
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign pc_wrapped_o  = pc_wrapped_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: models the PC adder and a zero-wait instruction memory.
module tb_pc_fetch_unit;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 32;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [PC_W-1:0]    pc_o;
  logic [PC_W-1:0]    inc_o;
  logic [PC_W-1:0]    pc_plus_i;
  logic               pc_cout_i;
  logic               branch_taken_i;
  logic [PC_W-1:0]    branch_target_i;
  logic               jump_i;
  logic [PC_W-1:0]    jump_target_i;
  logic               stall_i;
  logic               imem_req_o;
  logic [PC_W-1:0]    imem_addr_o;
  logic               imem_ack_i;
  logic [INSTR_W-1:0] imem_data_i;
  logic [INSTR_W-1:0] instr_o;
  logic               instr_valid_o;
  logic               instr_ready_i;
  logic               pc_wrapped_o;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0), .INC(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_o(pc_o), .inc_o(inc_o),
    .pc_plus_i(pc_plus_i), .pc_cout_i(pc_cout_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i), .stall_i(stall_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .pc_wrapped_o(pc_wrapped_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [INSTR_W-1:0] memWord(input int a);
    return 32'hC0DE_0000 + 32'(a) * 32'h0000_0101;
  endfunction

  // External adder and memory models driven from the DUT's address outputs.
  assign {pc_cout_i, pc_plus_i} = {1'b0, pc_o} + {1'b0, inc_o};
  assign imem_data_i = memWord(int'(imem_addr_o));

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    branch_taken_i = 1'b0; branch_target_i = '0;
    jump_i = 1'b0; jump_target_i = '0;
    stall_i = 1'b0; imem_ack_i = 1'b0; instr_ready_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    branch_taken_i = 1'b0; branch_target_i = '0;
    jump_i = 1'b0; jump_target_i = '0;
    stall_i = 1'b0; imem_ack_i = 1'b0; instr_ready_i = 1'b0;
    tick();
    total++; if (pc_o !== 6'd0) begin bad++; $display("[TB] FAIL reset_pc got=%0d want=0", pc_o); end
    total++; if (inc_o !== 6'd1) begin bad++; $display("[TB] FAIL reset_inc got=%0d want=1", inc_o); end
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got=%b want=0", imem_req_o); end
    total++; if (instr_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", instr_valid_o); end
    total++; if (instr_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_instr got=%h want=0", instr_o); end
    total++; if (pc_wrapped_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_wrapped got=%b want=0", pc_wrapped_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_sequential();
    doReset();
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 6'(i)) begin bad++; $display("[TB] FAIL seq_req%0d got req=%b addr=%0d want req=1 addr=%0d", i, imem_req_o, imem_addr_o, i); end
      imem_ack_i = 1'b1;
      tick();
      imem_ack_i = 1'b0; instr_ready_i = 1'b1;
      total++; if (instr_valid_o !== 1'b1 || instr_o !== memWord(i)) begin bad++; $display("[TB] FAIL seq_instr%0d got v=%b d=%h want v=1 d=%h", i, instr_valid_o, instr_o, memWord(i)); end
      total++; if (pc_o !== 6'(i + 1)) begin bad++; $display("[TB] FAIL seq_pc%0d got=%0d want=%0d", i, pc_o, i + 1); end
      tick();
      instr_ready_i = 1'b0;
      total++; if (instr_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL seq_pulse%0d got=%b want=0", i, instr_valid_o); end
    end
  endtask

  task automatic test_wait_ack();
    doReset();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 6'd0 || pc_o !== 6'd0 || instr_valid_o !== 1'b0) begin
        bad++; $display("[TB] FAIL wait_hold%0d got req=%b addr=%0d pc=%0d v=%b want 1,0,0,0", i, imem_req_o, imem_addr_o, pc_o, instr_valid_o);
      end
    end
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    total++; if (instr_valid_o !== 1'b1 || instr_o !== memWord(0) || pc_o !== 6'd1) begin
      bad++; $display("[TB] FAIL wait_capture got v=%b d=%h pc=%0d want v=1 d=%h pc=1", instr_valid_o, instr_o, pc_o, memWord(0));
    end
  endtask

  task automatic test_redirect_req();
    doReset();
    tick();
    jump_i = 1'b1; jump_target_i = 6'h20;
    branch_taken_i = 1'b1; branch_target_i = 6'h10;
    tick();
    jump_i = 1'b0; branch_taken_i = 1'b0;
    total++; if (imem_addr_o !== 6'd0) begin bad++; $display("[TB] FAIL redir_addr_stable got=%0d want=0", imem_addr_o); end
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    total++; if (instr_valid_o !== 1'b0 || pc_o !== 6'h20 || imem_req_o !== 1'b0) begin
      bad++; $display("[TB] FAIL redir_drop got v=%b pc=%h req=%b want v=0 pc=20 req=0", instr_valid_o, pc_o, imem_req_o);
    end
    tick();
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 6'h20) begin bad++; $display("[TB] FAIL redir_next got req=%b addr=%h want 1,20", imem_req_o, imem_addr_o); end
    // Branch arriving in the same cycle as the ack.
    branch_taken_i = 1'b1; branch_target_i = 6'h10; imem_ack_i = 1'b1;
    tick();
    branch_taken_i = 1'b0; imem_ack_i = 1'b0;
    total++; if (instr_valid_o !== 1'b0 || pc_o !== 6'h10) begin bad++; $display("[TB] FAIL redir_ackcycle got v=%b pc=%h want v=0 pc=10", instr_valid_o, pc_o); end
  endtask

  task automatic test_redirect_hold();
    doReset();
    tick();
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0; instr_ready_i = 1'b0;
    tick();
    total++; if (instr_valid_o !== 1'b1 || instr_o !== memWord(0)) begin bad++; $display("[TB] FAIL hold_stable got v=%b d=%h want v=1 d=%h", instr_valid_o, instr_o, memWord(0)); end
    branch_taken_i = 1'b1; branch_target_i = 6'h05; instr_ready_i = 1'b1;
    tick();
    branch_taken_i = 1'b0; instr_ready_i = 1'b0;
    total++; if (instr_valid_o !== 1'b0 || pc_o !== 6'h05 || imem_req_o !== 1'b0) begin
      bad++; $display("[TB] FAIL hold_redir got v=%b pc=%h req=%b want v=0 pc=05 req=0", instr_valid_o, pc_o, imem_req_o);
    end
    tick();
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 6'h05) begin bad++; $display("[TB] FAIL hold_next got req=%b addr=%h want 1,05", imem_req_o, imem_addr_o); end
    total++; if (pc_wrapped_o !== 1'b0) begin bad++; $display("[TB] FAIL hold_nowrap got=%b want=0", pc_wrapped_o); end
  endtask

  task automatic test_stall();
    doReset();
    stall_i = 1'b1;
    tick();
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL stall_idle got=%b want=0", imem_req_o); end
    stall_i = 1'b0;
    tick();
    stall_i = 1'b1; imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0; instr_ready_i = 1'b1;
    total++; if (instr_valid_o !== 1'b1 || instr_o !== memWord(0)) begin bad++; $display("[TB] FAIL stall_req got v=%b d=%h want v=1 d=%h", instr_valid_o, instr_o, memWord(0)); end
    tick();
    total++; if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL stall_hold got v=%b req=%b want v=1 req=0", instr_valid_o, imem_req_o); end
    stall_i = 1'b0;
    tick();
    instr_ready_i = 1'b0;
    total++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 6'd1) begin
      bad++; $display("[TB] FAIL stall_release got v=%b req=%b addr=%0d want 0,1,1", instr_valid_o, imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_wrap();
    doReset();
    jump_i = 1'b1; jump_target_i = 6'd63;
    tick();
    jump_i = 1'b0;
    total++; if (pc_o !== 6'd63 || imem_req_o !== 1'b1 || pc_wrapped_o !== 1'b0) begin
      bad++; $display("[TB] FAIL wrap_load got pc=%0d req=%b w=%b want 63,1,0", pc_o, imem_req_o, pc_wrapped_o);
    end
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    total++; if (pc_o !== 6'd0 || pc_wrapped_o !== 1'b1 || instr_o !== memWord(63)) begin
      bad++; $display("[TB] FAIL wrap_step got pc=%0d w=%b d=%h want 0,1,%h", pc_o, pc_wrapped_o, instr_o, memWord(63));
    end
    branch_taken_i = 1'b1; branch_target_i = 6'h10;
    tick();
    branch_taken_i = 1'b0;
    total++; if (pc_o !== 6'h10 || pc_wrapped_o !== 1'b1) begin bad++; $display("[TB] FAIL wrap_sticky got pc=%h w=%b want 10,1", pc_o, pc_wrapped_o); end
    doReset();
    total++; if (pc_wrapped_o !== 1'b0) begin bad++; $display("[TB] FAIL wrap_clear got=%b want=0", pc_wrapped_o); end
  endtask

  task automatic test_reset_mid_fetch();
    doReset();
    tick();
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0; instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    rst_i = 1'b1;
    #1;
    total++; if (pc_o !== 6'd0 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== 32'h0) begin
      bad++; $display("[TB] FAIL midrst_async got pc=%0d req=%b v=%b d=%h want all zero", pc_o, imem_req_o, instr_valid_o, instr_o);
    end
    tick();
    rst_i = 1'b0; stall_i = 1'b1; imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    total++; if (instr_valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 6'd0 || imem_req_o !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_lateack got v=%b d=%h pc=%0d req=%b want all zero", instr_valid_o, instr_o, pc_o, imem_req_o);
    end
    stall_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_ack();
    test_redirect_req();
    test_redirect_hold();
    test_stall();
    test_wrap();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
